mem_dm_ctrl: RTL

- Data-memory access controller in the MEM stage, directly downstream of the store-alignment unit. That unit produces the byte-lane write enables and the lane-aligned store data.
- Sequences one load or store per request to a word-addressed synchronous data memory using a ready handshake, and stalls the pipeline until the access completes.
- For loads, extracts the addressed byte/half/word from the returned word and zero- or sign-extends it.
- Bounds every access with a timeout and reports a bus error.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_load_ext.sv | 36 +++
 rtl/mem_dm_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dm_state_t;

  localparam int unsigned DM_WORD_W = 32;
  localparam int unsigned DM_ADDR_W = 30;

  typedef enum logic [1:0] {
    LD_NONE = 2'd0,
    LD_BYTE = 2'd1,
    LD_HALF = 2'd2,
    LD_WORD = 2'd3
  } ld_size_t;

  // Wider size wins if the decoder ever raises more than one flag.
  function automatic ld_size_t ld_size(input logic full, input logic half, input logic byte_acc);
    if (full)          return LD_WORD;
    else if (half)     return LD_HALF;
    else if (byte_acc) return LD_BYTE;
    else               return LD_NONE;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load lane select plus sign/zero extension of the returned memory word.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [DM_WORD_W-1:0] w,
  input  logic [1:0]           addr,
  input  logic                 full,
  input  logic                 half,
  input  logic                 byte_acc,
  input  logic                 load_signed,
  output logic [DM_WORD_W-1:0] rdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b     = '0;
    h     = '0;
    rdata = '0;
    case (addr)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = addr[1] ? w[31:16] : w[15:0];
    case (ld_size(full, half, byte_acc))
      LD_BYTE: rdata = {{24{load_signed & b[7]}}, b};
      LD_HALF: rdata = {{16{load_signed & h[15]}}, h};
      LD_WORD: rdata = w;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_dm_ctrl.sv
// MEM-stage data-memory access controller with ready handshake and timeout.
// Define MEM_DM_MISALIGN_EN to fault misaligned word/half accesses without a memory access.
// The byte-access flag is named byte_acc because byte is a reserved word.
module mem_dm_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic                 memwrite,
  input  logic                 memread,
  input  logic [3:0]           wen,
  input  logic [DM_WORD_W-1:0] wdata,
  input  logic [31:0]          addr,
  input  logic                 full,
  input  logic                 half,
  input  logic                 byte_acc,
  input  logic                 load_signed,
  output logic                 stall,
  output logic [DM_WORD_W-1:0] rdata,
  output logic                 rdata_valid,
  output logic                 bus_err,
  output logic                 mem_en,
  output logic [3:0]           mem_we,
  output logic [DM_ADDR_W-1:0] mem_addr,
  output logic [DM_WORD_W-1:0] mem_wdata,
  input  logic [DM_WORD_W-1:0] mem_rdata,
  input  logic                 mem_ready
);

  dm_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic [31:0]          a_addr;
  logic [3:0]           a_wen;
  logic [DM_WORD_W-1:0] a_wdata;
  logic                 a_full, a_half, a_byte, a_signed, a_write;
  logic                 err;
  logic                 accept, misalign, timeout;
  logic [DM_WORD_W-1:0] ext;

  assign accept  = req_valid && (memwrite || memread);
  assign timeout = (state == BUSY) && !mem_ready && (cnt == CNT_W'(TIMEOUT - 1));

`ifdef MEM_DM_MISALIGN_EN
  ld_size_t req_sz;
  assign req_sz   = ld_size(full, half, byte_acc);
  assign misalign = ((req_sz == LD_WORD) && (addr[1:0] != 2'b00)) ||
                    ((req_sz == LD_HALF) && addr[0]);
`else
  assign misalign = 1'b0;
`endif

  assign mem_addr  = a_addr[31:2];
  assign mem_wdata = a_wdata;

  mem_load_ext u_ext (
    .w           (mem_rdata),
    .addr        (a_addr[1:0]),
    .full        (a_full),
    .half        (a_half),
    .byte_acc    (a_byte),
    .load_signed (a_signed),
    .rdata       (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    stall       = 1'b0;
    mem_en      = 1'b0;
    mem_we      = '0;
    rdata_valid = 1'b0;
    bus_err     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          state_n = misalign ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall  = 1'b1;
        mem_en = 1'b1;
        mem_we = a_write ? a_wen : 4'b0000;
        if (mem_ready || timeout) state_n = DONE;
      end
      DONE: begin
        rdata_valid = 1'b1;
        bus_err     = err;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_addr   <= '0;
      a_wen    <= '0;
      a_wdata  <= '0;
      a_full   <= 1'b0;
      a_half   <= 1'b0;
      a_byte   <= 1'b0;
      a_signed <= 1'b0;
      a_write  <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_addr   <= addr;
            a_wen    <= wen;
            a_wdata  <= wdata;
            a_full   <= full;
            a_half   <= half;
            a_byte   <= byte_acc;
            a_signed <= load_signed;
            a_write  <= memwrite;
            cnt      <= '0;
            err      <= misalign;
            if (misalign) rdata <= '0;
          end
        end
        BUSY: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (mem_ready) begin
            err <= 1'b0;
            if (!a_write) rdata <= ext;
          end else if (timeout) begin
            err   <= 1'b1;
            rdata <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
